// File: rtl/mips_pkg.sv
// Shared widths, forward-select encodings and ID/EX control bundle for the MIPS core.
// Forwarding in id_ex_stage/hazard_unit is enabled by defining ID_EX_FORWARD_EN.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// Per-source hazard/bypass resolution for the ID/EX register (combinational).
// With ID_EX_FORWARD_EN undefined, any RAW match stalls and register-file data is used.
module hazard_unit
  import mips_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  uses,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_reg_write,
  input  logic                  ex_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic [DATA_W-1:0]     ex_mem_result,
  input  logic                  mem_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [DATA_W-1:0]     mem_wb_data,
  input  logic [DATA_W-1:0]     rf_data,
  output logic [1:0]            fwd,
  output logic [DATA_W-1:0]     data,
  output logic                  hazard
);

  logic live, m1, m2, m3;

  // Register 0 is hardwired, so it never matches anything.
  assign live = uses & (src != '0);
  assign m1   = live & ex_valid & ex_reg_write & (ex_rd == src);
  assign m2   = live & ex_mem_reg_write & (ex_mem_rd == src);
  assign m3   = live & mem_wb_reg_write & (mem_wb_rd == src);

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    fwd    = FWD_NONE;
    data   = rf_data;
    hazard = 1'b0;
    if (m1) begin
      if (ex_mem_read) hazard = 1'b1;
      else             fwd    = FWD_EXMEM;
    end else if (m2) begin
      if (ex_mem_mem_read) fwd  = FWD_MEMWB;
      else                 data = ex_mem_result;
    end else if (m3) begin
      data = mem_wb_data;
    end
  end
`else
  logic unused_bypass;

  assign fwd           = FWD_NONE;
  assign data          = rf_data;
  assign hazard        = m1 | m2 | m3;
  assign unused_bypass = ^{ex_mem_read, ex_mem_mem_read, ex_mem_result, mem_wb_data};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time bypass, EX forward selects and load-use stall.
// Define ID_EX_FORWARD_EN to enable forwarding; otherwise every RAW dependency stalls.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rt,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  flush,
  input  logic                  ex_mem_reg_write,
  input  logic                  ex_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic [DATA_W-1:0]     ex_mem_result,
  input  logic                  mem_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [DATA_W-1:0]     mem_wb_data,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_rs_val,
  output logic [DATA_W-1:0]     ex_rt_val,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [1:0]            ex_fwd_a,
  output logic [1:0]            ex_fwd_b
);

  ctrl_t             id_ctrl, ex_ctrl;
  logic [1:0]        fwd_a_d, fwd_b_d;
  logic [DATA_W-1:0] rs_val_d, rt_val_d;
  logic              haz_rs, haz_rt, bubble;

  assign id_ctrl = '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                     alu_src: id_alu_src, alu_op: id_alu_op};

  hazard_unit u_haz_rs (
    .src              (id_rs),
    .uses             (1'b1),
    .ex_valid         (ex_valid),
    .ex_reg_write     (ex_ctrl.reg_write),
    .ex_mem_read      (ex_ctrl.mem_read),
    .ex_rd            (ex_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_mem_read  (ex_mem_mem_read),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_result    (ex_mem_result),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_data      (mem_wb_data),
    .rf_data          (id_rs_data),
    .fwd              (fwd_a_d),
    .data             (rs_val_d),
    .hazard           (haz_rs)
  );

  hazard_unit u_haz_rt (
    .src              (id_rt),
    .uses             (id_uses_rt),
    .ex_valid         (ex_valid),
    .ex_reg_write     (ex_ctrl.reg_write),
    .ex_mem_read      (ex_ctrl.mem_read),
    .ex_rd            (ex_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_mem_read  (ex_mem_mem_read),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_result    (ex_mem_result),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_data      (mem_wb_data),
    .rf_data          (id_rt_data),
    .fwd              (fwd_b_d),
    .data             (rt_val_d),
    .hazard           (haz_rt)
  );

  // Flush wins over stall; a stalled ID instruction is re-presented next cycle.
  assign stall  = id_valid & ~flush & (haz_rs | haz_rt);
  assign bubble = ~id_valid | flush | stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      ex_valid  <= 1'b0;
      ex_rs_val <= '0;
      ex_rt_val <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_ctrl   <= CTRL_BUBBLE;
      ex_fwd_a  <= FWD_NONE;
      ex_fwd_b  <= FWD_NONE;
    end else begin
      ex_valid  <= 1'b1;
      ex_rs_val <= rs_val_d;
      ex_rt_val <= rt_val_d;
      ex_imm    <= id_imm;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
      ex_ctrl   <= id_ctrl;
      ex_fwd_a  <= fwd_a_d;
      ex_fwd_b  <= fwd_b_d;
    end
  end

  assign ex_reg_write = ex_ctrl.reg_write;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_alu_src   = ex_ctrl.alu_src;
  assign ex_alu_op    = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;

  logic        clk, rst;
  logic        id_valid, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
  logic [3:0]  id_alu_op;
  logic        flush;
  logic        ex_mem_reg_write, ex_mem_mem_read;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ex_mem_result;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        stall, ex_valid;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_fwd_a, ex_fwd_b;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .flush(flush),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_src = 0; id_alu_op = 0;
    flush = 0;
    ex_mem_reg_write = 0; ex_mem_mem_read = 0; ex_mem_rd = 0; ex_mem_result = 0;
    mem_wb_reg_write = 0; mem_wb_rd = 0; mem_wb_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic uses_rt, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic rw, input logic mr, input logic mw,
                         input logic as, input logic [3:0] op);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = uses_rt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_alu_src = as; id_alu_op = op;
  endtask

  // lw r5, 8(r1)
  task automatic present_lw();
    present(5'd1, 5'd0, 5'd5, 1'b0, 32'h100, 32'h0, 32'h8, 1, 1, 0, 1, 4'h0);
  endtask

  // add r7, r2, r5 (consumer of r5)
  task automatic present_use_r5();
    present(5'd2, 5'd5, 5'd7, 1'b1, 32'h1, 32'h2, 32'h0, 1, 0, 0, 0, 4'h2);
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    present(5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22, 32'h5, 1, 0, 0, 0, 4'h2);
    #2;
    check("rst_valid", ex_valid, 0);
    check("rst_stall", stall, 0);
    step();
    check("rst_hold_valid", ex_valid, 0);
    check("rst_hold_rs_val", ex_rs_val, 0);
    check("rst_hold_rw", ex_reg_write, 0);
    rst = 0;

    // add r3, r1, r2 captured without hazards
    #1;
    check("a_stall", stall, 0);
    step();
    check("a_valid", ex_valid, 1);
    check("a_rs_val", ex_rs_val, 32'h11);
    check("a_rt_val", ex_rt_val, 32'h22);
    check("a_imm", ex_imm, 32'h5);
    check("a_rd", ex_rd, 3);
    check("a_rw", ex_reg_write, 1);
    check("a_op", ex_alu_op, 2);
    check("a_fwd_a", ex_fwd_a, 0);

    // back-to-back dependency on r3; EX match must beat the EX/MEM match
    present(5'd3, 5'd4, 5'd6, 1'b1, 32'hAA, 32'hBB, 32'h0, 1, 0, 0, 0, 4'h3);
    ex_mem_reg_write = 1; ex_mem_rd = 3; ex_mem_result = 32'h5A5A;
    #1;
`ifdef ID_EX_FORWARD_EN
    check("b_stall", stall, 0);
    step();
    check("b_valid", ex_valid, 1);
    check("b_fwd_a", ex_fwd_a, 2'b01);
    check("b_rs_val", ex_rs_val, 32'hAA);
    check("b_fwd_b", ex_fwd_b, 0);
    check("b_rs", ex_rs, 3);
`else
    check("b_stall", stall, 1);
    step();
    check("b_valid", ex_valid, 0);
    check("b_rw", ex_reg_write, 0);
    check("b_fwd_a", ex_fwd_a, 0);
    check("b_op", ex_alu_op, 0);
`endif

    // load-use on rt
    do_reset();
    present_lw();
    step();
    check("lw_mr", ex_mem_read, 1);
    check("lw_as", ex_alu_src, 1);
    check("lw_imm", ex_imm, 32'h8);
    present_use_r5();
    #1;
    check("lu_stall", stall, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_mr", ex_mem_read, 0);
    check("lu_bubble_fwd_b", ex_fwd_b, 0);
    ex_mem_reg_write = 1; ex_mem_rd = 5; ex_mem_mem_read = 1; ex_mem_result = 32'h108;
    #1;
`ifdef ID_EX_FORWARD_EN
    check("lu2_stall", stall, 0);
    step();
    check("lu2_valid", ex_valid, 1);
    check("lu2_fwd_b", ex_fwd_b, 2'b10);
    check("lu2_rt_val", ex_rt_val, 32'h2);
    check("lu2_fwd_a", ex_fwd_a, 0);
`else
    check("lu2_stall", stall, 1);
    step();
    check("lu2_valid", ex_valid, 0);
    ex_mem_reg_write = 0; ex_mem_mem_read = 0;
    mem_wb_reg_write = 1; mem_wb_rd = 5; mem_wb_data = 32'h5555;
    #1;
    check("lu3_stall", stall, 1);
    step();
    check("lu3_valid", ex_valid, 0);
    mem_wb_reg_write = 0;
    #1;
    check("lu4_stall", stall, 0);
    step();
    check("lu4_valid", ex_valid, 1);
    check("lu4_rt_val", ex_rt_val, 32'h2);
    check("lu4_fwd_b", ex_fwd_b, 0);
`endif

    // EX/MEM ALU result bypass, which outranks MEM/WB
    do_reset();
    present(5'd4, 5'd0, 5'd9, 1'b0, 32'h4444, 32'h0, 32'h0, 1, 0, 0, 0, 4'h1);
    ex_mem_reg_write = 1; ex_mem_rd = 4; ex_mem_result = 32'h1234;
    mem_wb_reg_write = 1; mem_wb_rd = 4; mem_wb_data = 32'h9999;
    #1;
`ifdef ID_EX_FORWARD_EN
    check("em_stall", stall, 0);
    step();
    check("em_rs_val", ex_rs_val, 32'h1234);
    check("em_fwd_a", ex_fwd_a, 0);
`else
    check("em_stall", stall, 1);
    step();
    check("em_valid", ex_valid, 0);
`endif

    // MEM/WB bypass over stale register-file data
    do_reset();
    present(5'd7, 5'd8, 5'd2, 1'b0, 32'h0, 32'h33, 32'h0, 1, 0, 0, 0, 4'h0);
    mem_wb_reg_write = 1; mem_wb_rd = 7; mem_wb_data = 32'hDEADBEEF;
    #1;
`ifdef ID_EX_FORWARD_EN
    check("wb_stall", stall, 0);
    step();
    check("wb_rs_val", ex_rs_val, 32'hDEADBEEF);
    check("wb_fwd_a", ex_fwd_a, 0);
    check("wb_rt_val", ex_rt_val, 32'h33);
`else
    check("wb_stall", stall, 1);
    step();
    check("wb_valid", ex_valid, 0);
`endif

    // rt match ignored when rt is not a source
    do_reset();
    present(5'd8, 5'd7, 5'd2, 1'b0, 32'h88, 32'h33, 32'h0, 1, 0, 0, 0, 4'h0);
    mem_wb_reg_write = 1; mem_wb_rd = 7; mem_wb_data = 32'hDEADBEEF;
    #1;
    check("nort_stall", stall, 0);
    step();
    check("nort_valid", ex_valid, 1);
    check("nort_rt_val", ex_rt_val, 32'h33);
    check("nort_rt", ex_rt, 7);
    check("nort_rs_val", ex_rs_val, 32'h88);

    // register 0 never forwards or stalls
    do_reset();
    present(5'd1, 5'd2, 5'd0, 1'b1, 32'h1, 32'h2, 32'h0, 1, 0, 0, 0, 4'h0);
    step();
    present(5'd0, 5'd0, 5'd4, 1'b1, 32'h77, 32'h66, 32'h0, 1, 0, 0, 0, 4'h0);
    ex_mem_reg_write = 1; ex_mem_rd = 0; ex_mem_result = 32'hBAD;
    mem_wb_reg_write = 1; mem_wb_rd = 0; mem_wb_data = 32'hBAD;
    #1;
    check("r0_stall", stall, 0);
    step();
    check("r0_valid", ex_valid, 1);
    check("r0_rs_val", ex_rs_val, 32'h77);
    check("r0_rt_val", ex_rt_val, 32'h66);
    check("r0_fwd_a", ex_fwd_a, 0);
    check("r0_fwd_b", ex_fwd_b, 0);

    // flush during a load-use hazard
    do_reset();
    present_lw();
    step();
    present_use_r5();
    flush = 1;
    #1;
    check("fl_stall", stall, 0);
    step();
    check("fl_valid", ex_valid, 0);
    check("fl_rw", ex_reg_write, 0);
    flush = 0;

    // id_valid low during a hazard captures a bubble without stalling
    do_reset();
    present_lw();
    step();
    present_use_r5();
    id_valid = 0;
    #1;
    check("iv_stall", stall, 0);
    step();
    check("iv_valid", ex_valid, 0);
    check("iv_rw", ex_reg_write, 0);
    check("iv_rt", ex_rt, 0);

    // reset asserted mid-stall clears immediately and leaves no stall behind
    do_reset();
    present_lw();
    step();
    present_use_r5();
    #1;
    check("rs_stall_before", stall, 1);
    #2;
    rst = 1;
    #1;
    check("rs_valid", ex_valid, 0);
    check("rs_mr", ex_mem_read, 0);
    check("rs_rd", ex_rd, 0);
    check("rs_stall", stall, 0);
    step();
    rst = 0;
    #1;
    check("rs_after_stall", stall, 0);
    step();
    check("rs_after_valid", ex_valid, 1);
    check("rs_after_rt", ex_rt, 5);
    check("rs_after_rw", ex_reg_write, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
